// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state
// encoding, bubble encoding and the per-stage control bundle.
package pipeline_ctrl_pkg;

  // Sequencer state encoding (kept as plain 3-bit constants so legacy
  // code that compares raw state values keeps working).
  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_MEM_WAIT = 3'd1;
  localparam logic [2:0] ST_FLUSH    = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_HALTED   = 3'd4;

  // Instruction word a flushed pipeline register loads (bubble).
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Per-stage register controls produced each cycle.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctrl_t;

  // Everything advances, nothing flushed.
  localparam stage_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  // Whole pipeline frozen (memory wait, halted).
  localparam stage_ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Taken redirect: PC loads target, the two younger stages become bubbles.
  localparam stage_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // Tail of a multi-cycle redirect: keep fetching, squash IF/ID only.
  localparam stage_ctrl_t CTRL_FLUSH_IF = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  // Hold PC, bubble into ID, older stages advance (hazard, halt, drain).
  localparam stage_ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  // Forced while rst_n is low.
  localparam stage_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Event inputs and stage controls exchanged between the pipeline
// datapath (master) and the stall/flush sequencer (slave).
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard;
  logic             ex_redirect;
  logic             mem_op;
  logic             mem_ready;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_req;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hazard, ex_redirect, mem_op, mem_ready, halt_req, resume,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_req, halted, stall_count
  );

  modport slave (
    input  hazard, ex_redirect, mem_op, mem_ready, halt_req, resume,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_req, halted, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1'b1);

  logic [W-1:0] count_r;

  // Count up on inc, stick at all-ones, clear when clr_n is low.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: merges memory waits,
// EX redirects, halt requests and RAW hazards into stage enables/flushes.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [1:0]  fcnt_r;
  logic [1:0]  fcnt_next_s;
  logic [2:0]  dcnt_r;
  logic [2:0]  dcnt_next_s;
  stage_ctrl_t ctrl_s;
  logic        mem_req_s;
  logic        halted_s;
  logic        mem_stall_s;
  logic        stall_inc_s;

  assign mem_stall_s = bus.mem_op & ~bus.mem_ready;

  // Next-state and stage-control decode; priority in RUN is
  // memory stall > redirect > halt > hazard > normal.
  always_comb begin
    state_next_s = state_r;
    fcnt_next_s  = fcnt_r;
    dcnt_next_s  = dcnt_r;
    ctrl_s       = CTRL_FROZEN;
    mem_req_s    = 1'b0;
    halted_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        mem_req_s = bus.mem_op;
        if (mem_stall_s) begin
          ctrl_s       = CTRL_FROZEN;
          state_next_s = ST_MEM_WAIT;
        end else if (bus.ex_redirect) begin
          ctrl_s = CTRL_REDIRECT;
          if (FLUSH_CYCLES > 1) begin
            state_next_s = ST_FLUSH;
            fcnt_next_s  = FLUSH_RELOAD;
          end else begin
            state_next_s = ST_RUN;
          end
        end else if (bus.halt_req) begin
          ctrl_s       = CTRL_BUBBLE;
          state_next_s = ST_DRAIN;
          dcnt_next_s  = DRAIN_RELOAD;
        end else if (bus.hazard) begin
          ctrl_s = CTRL_BUBBLE;
        end else begin
          ctrl_s = CTRL_NORMAL;
        end
      end
      ST_MEM_WAIT: begin
        // Redirect/hazard are frozen in place and handled back in RUN.
        mem_req_s = bus.mem_op;
        if (bus.mem_ready) begin
          ctrl_s       = CTRL_NORMAL;
          state_next_s = ST_RUN;
        end else begin
          ctrl_s = CTRL_FROZEN;
        end
      end
      ST_FLUSH: begin
        if (bus.ex_redirect) begin
          ctrl_s      = CTRL_REDIRECT;
          fcnt_next_s = FLUSH_RELOAD;
        end else begin
          ctrl_s = CTRL_FLUSH_IF;
          if (fcnt_r <= 2'd1) begin
            fcnt_next_s  = 2'd0;
            state_next_s = ST_RUN;
          end else begin
            fcnt_next_s = fcnt_r - 2'd1;
          end
        end
      end
      ST_DRAIN: begin
        // A memory stall freezes the drain and holds the countdown.
        if (mem_stall_s) begin
          ctrl_s = CTRL_FROZEN;
        end else begin
          ctrl_s = CTRL_BUBBLE;
          if (dcnt_r == 3'd0) begin
            state_next_s = ST_HALTED;
          end else begin
            dcnt_next_s = dcnt_r - 3'd1;
          end
        end
      end
      ST_HALTED: begin
        ctrl_s   = CTRL_FROZEN;
        halted_s = 1'b1;
        if (bus.resume) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      default: begin
        // Unreachable encodings recover to RUN with a frozen pipeline.
        ctrl_s       = CTRL_FROZEN;
        state_next_s = ST_RUN;
        fcnt_next_s  = 2'd0;
        dcnt_next_s  = 3'd0;
      end
    endcase
  end

  // Sequencer state and countdown registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      fcnt_r  <= 2'd0;
      dcnt_r  <= 3'd0;
    end else begin
      state_r <= state_next_s;
      fcnt_r  <= fcnt_next_s;
      dcnt_r  <= dcnt_next_s;
    end
  end

  // Drive stage controls; reset forces bubbles and a stopped pipeline.
  always_comb begin
    if (!rst_n) begin
      bus.pc_en       = CTRL_RESET.pc_en;
      bus.if_id_en    = CTRL_RESET.if_id_en;
      bus.if_id_flush = CTRL_RESET.if_id_flush;
      bus.id_ex_en    = CTRL_RESET.id_ex_en;
      bus.id_ex_flush = CTRL_RESET.id_ex_flush;
      bus.ex_mem_en   = CTRL_RESET.ex_mem_en;
      bus.mem_wb_en   = CTRL_RESET.mem_wb_en;
      bus.mem_req     = 1'b0;
      bus.halted      = 1'b0;
    end else begin
      bus.pc_en       = ctrl_s.pc_en;
      bus.if_id_en    = ctrl_s.if_id_en;
      bus.if_id_flush = ctrl_s.if_id_flush;
      bus.id_ex_en    = ctrl_s.id_ex_en;
      bus.id_ex_flush = ctrl_s.id_ex_flush;
      bus.ex_mem_en   = ctrl_s.ex_mem_en;
      bus.mem_wb_en   = ctrl_s.mem_wb_en;
      bus.mem_req     = mem_req_s;
      bus.halted      = halted_s;
    end
  end

  // Stall cycles are those with the PC held, except while parked in HALTED.
  assign stall_inc_s = rst_n & ~ctrl_s.pc_en & (state_r != ST_HALTED);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (stall_inc_s),
    .count (bus.stall_count)
  );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit five-stage pipeline (IF, ID, EX, MEM, WB).
- Combines these events into per-stage register enables and flush controls:
  - the RAW hazard flag from hazard_detection;
  - EX-stage redirects (taken B, CALL, RET);
  - the data-memory handshake for LW/SW;
  - halt requests.
- Also owns the PC write enable and a saturating stall-cycle counter for performance monitoring.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a redirect (1..3).
- DRAIN_CYCLES, 3: cycles allowed for ID/EX/MEM to drain before HALTED (1..7).
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- hazard  in  1  RAW hazard on the instruction in IF (from hazard_detection).
- ex_redirect  in  1  EX resolved a taken B, CALL or RET this cycle.
- mem_op  in  1  MEM stage holds a valid LW or SW.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- halt_req  in  1  halt instruction decoded in ID.
- resume  in  1  restart request while halted.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID loads a NOP bubble.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX loads a NOP bubble.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- mem_req  out  1  request to data memory.
- halted  out  1  core is stopped.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0 outside HALTED.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Outputs are combinational from the registered state and current inputs.
- While rst_n=0, outputs are forced to:
  - all *_en=0 and mem_req=0;
  - if_id_flush=1 and id_ex_flush=1;
  - halted=0.
- At the rising edge with rst_n=0: state=RUN, counters=0, stall_count=0. Reset mid-operation abandons any wait, flush or drain.
- States: RUN, MEM_WAIT, FLUSH, DRAIN, HALTED.
- Priority within RUN: memory stall > redirect > halt > hazard > normal.
- mem_req = mem_op in RUN and MEM_WAIT; 0 in other states.
- RUN, normal: all enables=1, flushes=0.
- RUN, mem_op=1 and mem_ready=0:
  - all enables=0 (pipeline frozen);
  - next state MEM_WAIT.
  - If mem_ready=1 in the same cycle as mem_op, there is no stall (zero-wait access).
- MEM_WAIT:
  - Enables stay 0 until mem_ready=1.
  - In that cycle, outputs equal RUN-normal and next state is RUN.
  - ex_redirect and hazard are held stable by the frozen pipeline and are evaluated in the next RUN cycle.
- RUN, ex_redirect=1:
  - pc_en=1 (loads target);
  - if_id_flush=1, id_ex_flush=1;
  - ex_mem_en=1, mem_wb_en=1.
  - If FLUSH_CYCLES>1: go to FLUSH with fcnt=FLUSH_CYCLES-1.
  - hazard and halt_req are ignored in this cycle.
- FLUSH:
  - pc_en=1, if_id_flush=1, others advance.
  - fcnt decrements; return to RUN when fcnt reaches 0.
  - A new ex_redirect here restarts fcnt.
- RUN, halt_req=1:
  - pc_en=0, if_id_flush=1, others advance.
  - Go to DRAIN with dcnt=DRAIN_CYCLES-1.
- DRAIN:
  - Same outputs as halt entry.
  - A mem stall still freezes all stages and dcnt holds.
  - When dcnt=0, go to HALTED.
- HALTED:
  - All enables=0, halted=1.
  - resume=1 → RUN on the next cycle; halted deasserts in the same cycle as the transition.
- RUN, hazard=1 with nothing of higher priority:
  - pc_en=0, if_id_flush=1 (bubble into ID);
  - id_ex_en, ex_mem_en, mem_wb_en=1.
  - Stays in RUN; each cycle is re-evaluated.
- stall_count:
  - Increments on every cycle with pc_en=0 and state≠HALTED.
  - Saturates at 2^CNT_W-1 with no wrap.

Decomposition:
- Header pipe_ctrl.h holds:
  - state encoding localparams (3-bit: RUN=0, MEM_WAIT=1, FLUSH=2, DRAIN=3, HALTED=4);
  - the bubble/NOP encoding, shared with the pipeline registers.
- Opcode constants remain in opcode.h.
- One natural sub-module: sat_counter (parameterised width, inc, sync active-low clear), used for stall_count.

Test Plan:
- Reset, then release with all inputs 0 → first cycle all enables=1, flushes=0, stall_count=0.
- hazard=1 for 2 cycles → pc_en=0 and if_id_flush=1 for exactly 2 cycles; id_ex_en=1; stall_count=2.
- mem_op=1, mem_ready=0 for 3 cycles, then 1 → all enables=0 for 3 cycles, normal on the 4th; mem_req=1 for all 4; ex_redirect arriving during the wait is acted on only after release.
- FLUSH_CYCLES=2: ex_redirect together with hazard → pc_en=1, if_id_flush=1 for 2 cycles, id_ex_flush=1 in the first only; hazard ignored in cycle 1.
- halt_req=1 → 3 cycles of DRAIN (pc_en=0), then halted=1 with all enables=0; resume=1 → RUN next cycle; stall_count stops counting while HALTED.
- stall_count saturation (CNT_W=4, hazard held 20 cycles) → stays at 15; rst_n=0 mid-MEM_WAIT → RUN and counter=0 next cycle.
